ov7670_pixel_packer: RTL

- Sits directly downstream of the OV7670 capture stage, in the pclk_24 domain.
- Consumes the registered byte stream (din/vde) plus the sensor vsync.
- Pairs consecutive bytes into RGB565 pixels and generates linear framebuffer write addresses for a QVGA frame.
- Flags malformed lines and frames, and pulses frame_done for the display/readout side.

---
 rtl/ov7670_pixel_packer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_packer.sv
// OV7670 byte-pair packer: RGB565 pixels, linear framebuffer
// addressing, per-line and per-frame integrity flags.
module ov7670_pixel_packer #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk_24,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              vde,
  input  logic [7:0]        din,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    VBLANK,
    ACTIVE
  } state_t;

  state_t            state;
  logic              vde_d;
  logic              vsync_d;
  logic [XW-1:0]     x;
  logic              x_ovf;
  logic [YW-1:0]     y;
  logic              y_ovf;
  logic [ADDR_W-1:0] line_base;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              frame_bad;

  logic          vde_fall;
  logic          vsync_rise;
  logic          vsync_fall;
  logic          line_end;
  logic          y_in;
  logic          lerr;
  logic [YW-1:0] y_nx;
  logic          ovf_nx;
  logic          frame_ok;

  always_comb begin
    vde_fall   = vde_d & ~vde;
    vsync_rise = ~vsync_d & vsync;
    vsync_fall = vsync_d & ~vsync;
    // vsync rising mid-line closes that line before the frame
    line_end   = vde_fall | (vsync_rise & vde);
    y_in       = (y < Y_MAX);
    lerr       = line_end & y_in &
                 ((x != X_MAX) | phase | x_ovf);
    y_nx       = (line_end & y_in) ? y + 1'b1 : y;
    ovf_nx     = y_ovf | (line_end & ~y_in);
    frame_ok   = (y_nx == Y_MAX) & ~ovf_nx &
                 ~frame_bad & ~lerr;
  end

  always_ff @(posedge pclk_24 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vde_d      <= 1'b0;
      vsync_d    <= 1'b0;
      x          <= '0;
      x_ovf      <= 1'b0;
      y          <= '0;
      y_ovf      <= 1'b0;
      line_base  <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      frame_bad  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vde_d      <= vde;
      vsync_d    <= vsync;
      wr_en      <= 1'b0;
      line_err   <= 1'b0;
      frame_done <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        phase     <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: if (vsync) state <= VBLANK;
          VBLANK: begin
            if (vsync_fall) begin
              state     <= ACTIVE;
              x         <= '0;
              x_ovf     <= 1'b0;
              y         <= '0;
              y_ovf     <= 1'b0;
              line_base <= '0;
              phase     <= 1'b0;
              frame_bad <= 1'b0;
            end
          end
          ACTIVE: begin
            if (vde && !vsync_rise) begin
              if (!phase) begin
                hi_byte <= din;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (x < X_MAX && y_in) begin
                  wr_en   <= 1'b1;
                  wr_data <= {hi_byte, din};
                  wr_addr <= line_base + ADDR_W'(x);
                  x       <= x + 1'b1;
                end else if (y_in) begin
                  x_ovf <= 1'b1;
                end
              end
            end
            if (line_end) begin
              line_err <= lerr;
              if (lerr) frame_bad <= 1'b1;
              x     <= '0;
              x_ovf <= 1'b0;
              phase <= 1'b0;
              if (y_in) begin
                y         <= y + 1'b1;
                line_base <= line_base + STEP;
              end else begin
                y_ovf <= 1'b1;
              end
            end
            if (vsync_rise) begin
              if (frame_ok) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= VBLANK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
